// File: rtl/mux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_pkg : shared types, select-width rule and arbitration mode for rr_mux_n
// Rev 1.0 | build option: RR_MUX_FIXED_PRIO_EN (channel 0 fixed priority)
// ---------------------------------------------------------------------------
package mux_pkg;

  typedef logic [31:0] word_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // base and off are both below n, so one conditional subtract replaces a modulo
  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off >= n) ? (base + off - n) : (base + off);
  endfunction

`ifdef RR_MUX_FIXED_PRIO_EN
  localparam bit FIXED_PRIO_EN = 1'b1;
`else
  localparam bit FIXED_PRIO_EN = 1'b0;
`endif

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : rotating priority-find, first requester at or after ptr wins
// Rev 1.0 | build option: RR_MUX_FIXED_PRIO_EN (channel 0 fixed priority)
// ---------------------------------------------------------------------------
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    if (FIXED_PRIO_EN && en && req[0]) begin
      gnt[0] = 1'b1;
      found  = 1'b1;
    end
    for (int off = 0; off < N; off++) begin
      if (en && !found && req[wrap_add(int'(ptr), off, N)]) begin
        gnt[wrap_add(int'(ptr), off, N)] = 1'b1;
        gnt_idx = SELW'(wrap_add(int'(ptr), off, N));
        found   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_mux_n : N:1 round-robin data mux with a registered valid/ready output
// Rev 1.0 | build option: RR_MUX_FIXED_PRIO_EN (channel 0 fixed priority)
// ---------------------------------------------------------------------------
module rr_mux_n
  import mux_pkg::*;
#(
  parameter  int WIDTH = $bits(word_t),
  parameter  int N     = 4,
  localparam int SELW  = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;

  logic             load;
  logic             arb_en;
  logic [N-1:0]     gnt;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  ptr_inc;
  logic [WIDTH-1:0] gnt_data;

  // Accept a new word when the register is empty or being drained this cycle.
  assign load   = !out_valid_q || out_ready;
  assign arb_en = load && !reset;

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = gnt;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gnt_data = gnt_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  generate
    if (N == 1) begin : g_ptr_const
      assign ptr_inc = '0;
    end else begin : g_ptr_rr
      assign ptr_inc = (gnt_idx == SELW'(N - 1)) ? '0 : (gnt_idx + SELW'(1));
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (|gnt) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
      if (!(FIXED_PRIO_EN && gnt[0])) begin
        ptr_d = ptr_inc;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

  a_gnt_onehot: assert property (@(posedge clk) $onehot0(in_ready));

  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_sel_q)));

  a_ptr_range: assert property (@(posedge clk) disable iff (reset) (int'(ptr_q) < N));

endmodule
`default_nettype wire
